// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and helpers for the PS/2 digit sender.
// Make codes follow PS/2 scan code set 2 for the main-row digit keys.
package ps2_pkg;

  localparam logic [7:0] MAKE_0 = 8'h45;
  localparam logic [7:0] MAKE_1 = 8'h16;
  localparam logic [7:0] MAKE_2 = 8'h1E;
  localparam logic [7:0] MAKE_3 = 8'h26;
  localparam logic [7:0] MAKE_4 = 8'h25;
  localparam logic [7:0] MAKE_5 = 8'h2E;
  localparam logic [7:0] MAKE_6 = 8'h36;
  localparam logic [7:0] MAKE_7 = 8'h3D;
  localparam logic [7:0] MAKE_8 = 8'h3E;
  localparam logic [7:0] MAKE_9 = 8'h46;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam int         FRAME_BITS   = 11;

  typedef enum logic [1:0] {TX_IDLE, TX_HI, TX_LO} tx_state_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_FRAME, ST_GAP, ST_DONE, ST_ERR
  } seq_state_e;

  // Returns {valid, make_code}; valid is low for digits 10..15.
  function automatic logic [8:0] digit_to_make(input logic [3:0] num);
    case (num)
      4'd0:    return {1'b1, MAKE_0};
      4'd1:    return {1'b1, MAKE_1};
      4'd2:    return {1'b1, MAKE_2};
      4'd3:    return {1'b1, MAKE_3};
      4'd4:    return {1'b1, MAKE_4};
      4'd5:    return {1'b1, MAKE_5};
      4'd6:    return {1'b1, MAKE_6};
      4'd7:    return {1'b1, MAKE_7};
      4'd8:    return {1'b1, MAKE_8};
      4'd9:    return {1'b1, MAKE_9};
      default: return 9'h000;
    endcase
  endfunction

  // Line level for frame bit idx: start, data LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    if (idx == 4'd0)       return 1'b0;
    else if (idx <= 4'd8)  return b[3'(idx - 4'd1)];
    else if (idx == 4'd9)  return ~^b;
    else                   return 1'b1;
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Serialises one byte as an 11-bit PS/2 device-to-host frame and generates
// the PS/2 clock; both lines rest high while idle.
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_idle,
  output logic       o_ps2_clk,
  output logic       o_ps2_data
);

  localparam int DW = $clog2(CLK_DIV);

  tx_state_e      state_q, state_d;
  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     byte_q, byte_d;
  logic           clk_q, clk_d;
  logic           data_q, data_d;
  logic           idle_q, idle_d;

  // NOTE: every always_comb output gets its hold value first so no path
  // leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    clk_d     = clk_q;
    data_d    = data_q;
    case (state_q)
      TX_IDLE: begin
        if (i_start) begin
          state_d   = TX_HI;
          byte_d    = i_byte;
          bit_cnt_d = 4'd0;
          div_cnt_d = '0;
          clk_d     = 1'b1;
          data_d    = 1'b0;
        end
      end
      TX_HI: begin
        if (div_cnt_q == DW'(CLK_DIV - 1)) begin
          state_d   = TX_LO;
          div_cnt_d = '0;
          clk_d     = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      TX_LO: begin
        if (div_cnt_q == DW'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          clk_d     = 1'b1;
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            state_d   = TX_IDLE;
            bit_cnt_d = 4'd0;
            data_d    = 1'b1;
          end else begin
            state_d   = TX_HI;
            bit_cnt_d = bit_cnt_q + 4'd1;
            data_d    = frame_bit(byte_q, bit_cnt_q + 4'd1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
    idle_d = (state_d == TX_IDLE);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= TX_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= 4'd0;
      byte_q    <= 8'h00;
      clk_q     <= 1'b1;
      data_q    <= 1'b1;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      clk_q     <= clk_d;
      data_q    <= data_d;
      idle_q    <= idle_d;
    end
  end

  assign o_idle     = idle_q;
  assign o_ps2_clk  = clk_q;
  assign o_ps2_data = data_q;

endmodule

// File: rtl/ps2_digit_sender.sv
// PS/2 keyboard emulator: accepts a decimal digit and sends make, F0, make,
// with an idle gap after every frame.
module ps2_digit_sender
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_num,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_ps2_clk,
  output logic       o_ps2_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int CNT_MAX  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW       = $clog2(CNT_MAX);
  // The cycle in which FRAME observes the transmitter idle is the first gap cycle.
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

  seq_state_e    state_q, state_d;
  logic [7:0]    make_q, make_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [8:0]    digit;
  logic          gap_over;
  logic          tx_idle;
  logic          tx_start;
  logic [7:0]    tx_byte;

  assign tx_start = (state_q == ST_LOAD);
  assign tx_byte  = (byte_idx_q == 2'd1) ? BREAK_PREFIX : make_q;

  ps2_frame_tx #(.CLK_DIV(CLK_DIV)) u_frame_tx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (tx_start),
    .i_byte     (tx_byte),
    .o_idle     (tx_idle),
    .o_ps2_clk  (o_ps2_clk),
    .o_ps2_data (o_ps2_data)
  );

  always_comb begin
    state_d    = state_q;
    make_d     = make_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    gap_over   = 1'b0;
    digit      = digit_to_make(i_num);
    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          if (digit[8]) begin
            make_d     = digit[7:0];
            byte_idx_d = 2'd0;
            state_d    = ST_LOAD;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_LOAD:  state_d = ST_FRAME;
      ST_FRAME: begin
        if (tx_idle) begin
          if (GAP_CYCLES == 1) begin
            gap_over = 1'b1;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == CW'(GAP_LAST)) gap_over = 1'b1;
        else                           gap_cnt_d = gap_cnt_q + CW'(1);
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
    if (gap_over) begin
      gap_cnt_d = '0;
      if (byte_idx_q == 2'd2) begin
        state_d = ST_DONE;
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
        state_d    = ST_LOAD;
      end
    end
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      make_q     <= 8'h00;
      byte_idx_q <= 2'd0;
      gap_cnt_q  <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      make_q     <= make_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_ps2_digit_sender.sv
// Bench for ps2_digit_sender: a PS/2 host receiver model decodes frames and
// compares them against a queue of expected bytes pushed at each accept.
module tb_ps2_digit_sender;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;
  localparam int LATENCY = 3 * (1 + 22 * CLK_DIV + GAP) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_num;
  logic       i_valid;
  logic       o_ready, o_ps2_clk, o_ps2_data, o_busy, o_done, o_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q [$];
  logic [10:0] frame_log [$];
  logic [10:0] rx_bits;
  int          rx_cnt   = 0;
  int          fall_cnt = 0;
  logic        prev_clk = 1'b1;

  logic [7:0] map_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  always #5 clk = ~clk;

  ps2_digit_sender #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_num      (i_num),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_ps2_clk  (o_ps2_clk),
    .o_ps2_data (o_ps2_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  // Host receiver: samples data on each falling PS/2 clock edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      rx_cnt   = 0;
      prev_clk = 1'b1;
    end else begin
      if (prev_clk === 1'b1 && o_ps2_clk === 1'b0) begin
        rx_bits[rx_cnt] = o_ps2_data;
        fall_cnt++;
        rx_cnt++;
        if (rx_cnt == 11) begin
          rx_cnt = 0;
          frame_log.push_back(rx_bits);
          checks++;
          if (rx_bits[0] !== 1'b0 || rx_bits[10] !== 1'b1 || rx_bits[9] !== ~^rx_bits[8:1]) begin
            errors++;
            $display("FAIL frame_format got %b need start=0 parity=%b stop=1", rx_bits, ~^rx_bits[8:1]);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame got %h need none", rx_bits[8:1]);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rx_bits[8:1] !== e) begin
              errors++;
              $display("FAIL frame_byte got %h need %h", rx_bits[8:1], e);
            end
          end
        end
      end
      prev_clk = o_ps2_clk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_digit(input logic [3:0] d);
    exp_q.push_back(map_tab[d]);
    exp_q.push_back(8'hF0);
    exp_q.push_back(map_tab[d]);
  endtask

  // Leaves the bench at the sample point right after the accepting edge.
  task automatic send(input logic [3:0] d);
    int k;
    k = 0;
    while (o_ready !== 1'b1 && k < 1000) begin tick(); k++; end
    if (k >= 1000) begin
      checks++; errors++;
      $display("FAIL ready_timeout got o_ready=%b need 1", o_ready);
    end
    i_num   = d;
    i_valid = 1'b1;
    if (d <= 4'd9) push_digit(d);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (o_done !== 1'b1 && n < LATENCY + 50) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_num = 4'd0;
    repeat (3) tick();
    checks++;
    if ({o_ready, o_ps2_clk, o_ps2_data, o_busy, o_done, o_err} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_outputs got %b need 111000",
               {o_ready, o_ps2_clk, o_ps2_data, o_busy, o_done, o_err});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b busy=%b need 1 0", o_ready, o_busy);
    end
  endtask

  task automatic test_single();
    int n, base_f, base_fr;
    base_f  = fall_cnt;
    base_fr = frame_log.size();
    send(4'd1);
    i_num = 4'd9;
    wait_done(n);
    checks++;
    if (n != LATENCY) begin
      errors++; $display("FAIL single_latency got %0d need %0d", n, LATENCY);
    end
    checks++;
    if (fall_cnt - base_f != 33) begin
      errors++; $display("FAIL single_falls got %0d need 33", fall_cnt - base_f);
    end
    checks++;
    if (frame_log.size() < base_fr + 3 || frame_log[base_fr] !== 11'b100_0010_1100) begin
      errors++; $display("FAIL frame1_bits got %b need 10000101100",
                         (frame_log.size() > base_fr) ? frame_log[base_fr] : 11'hx);
    end
    checks++;
    if (frame_log.size() < base_fr + 3 || frame_log[base_fr + 1][9] !== 1'b1) begin
      errors++; $display("FAIL f0_parity got size=%0d need parity 1", frame_log.size() - base_fr);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL done_pulse got done=%b ready=%b need 0 1", o_done, o_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n, base_fr;
    base_fr = frame_log.size();
    for (int d = 0; d < 10; d++) begin
      send(4'(d));
      wait_done(n);
      checks++;
      if (n != LATENCY) begin
        errors++; $display("FAIL b2b_latency digit %0d got %0d need %0d", d, n, LATENCY);
      end
    end
    tick();
    checks++;
    if (exp_q.size() != 0 || frame_log.size() - base_fr != 30) begin
      errors++; $display("FAIL b2b_frames got %0d pending=%0d need 30 pending=0",
                         frame_log.size() - base_fr, exp_q.size());
    end
  endtask

  task automatic test_err();
    int base_f;
    base_f = fall_cnt;
    send(4'd12);
    checks++;
    if (o_err !== 1'b1 || o_ready !== 1'b0 || o_ps2_clk !== 1'b1 || o_ps2_data !== 1'b1) begin
      errors++; $display("FAIL err_pulse got err=%b ready=%b clk=%b data=%b need 1 0 1 1",
                         o_err, o_ready, o_ps2_clk, o_ps2_data);
    end
    tick();
    checks++;
    if (o_err !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL err_return got err=%b ready=%b busy=%b need 0 1 0",
                         o_err, o_ready, o_busy);
    end
    repeat (20) tick();
    checks++;
    if (fall_cnt != base_f) begin
      errors++; $display("FAIL err_no_frames got %0d falls need 0", fall_cnt - base_f);
    end
  endtask

  task automatic test_ignore();
    int n;
    send(4'd3);
    i_num   = 4'd5;
    i_valid = 1'b1;
    wait_done(n);
    checks++;
    if (n != LATENCY || exp_q.size() != 0) begin
      errors++; $display("FAIL ignore_first got latency=%0d pending=%0d need %0d 0",
                         n, exp_q.size(), LATENCY);
    end
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL ignore_ready got ready=%b busy=%b need 1 0", o_ready, o_busy);
    end
    push_digit(4'd5);
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL ignore_accept got ready=%b busy=%b need 0 1", o_ready, o_busy);
    end
    wait_done(n);
    checks++;
    if (n != LATENCY) begin
      errors++; $display("FAIL ignore_second got %0d need %0d", n, LATENCY);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n, k, base_fr, base_fr2;
    bit saw_done;
    base_fr = frame_log.size();
    send(4'd4);
    k = 0;
    while (!(frame_log.size() == base_fr + 1 && rx_cnt >= 4) && k < 1000) begin tick(); k++; end
    checks++;
    if (k >= 1000) begin
      errors++; $display("FAIL mid_frame2_timeout got frames=%0d need 1", frame_log.size() - base_fr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (o_ps2_clk !== 1'b1 || o_ps2_data !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got clk=%b data=%b busy=%b done=%b need 1 1 0 0",
                         o_ps2_clk, o_ps2_data, o_busy, o_done);
    end
    rst = 1'b0;
    exp_q.delete();
    base_fr2 = frame_log.size();
    saw_done = 1'b0;
    repeat (400) begin
      tick();
      if (o_done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || frame_log.size() != base_fr2) begin
      errors++; $display("FAIL mid_abandon got done=%0d frames=%0d need 0 0",
                         saw_done, frame_log.size() - base_fr2);
    end
    send(4'd7);
    wait_done(n);
    checks++;
    if (n != LATENCY || exp_q.size() != 0 || frame_log.size() != base_fr2 + 3) begin
      errors++; $display("FAIL after_reset_7 got latency=%0d frames=%0d pending=%0d need %0d 3 0",
                         n, frame_log.size() - base_fr2, exp_q.size(), LATENCY);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_err();
    test_ignore();
    test_reset_mid();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
